// File: rtl/cronometro_bcd.sv
// rtl/cronometro_bcd.sv - MM:SS BCD stopwatch counting prescaler carry ticks
// Run/pause FSM gates counting; a lap register can freeze the displayed time.
module cronometro_bcd #(
  parameter int WRAP_MIN = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] seg_uni,
  output logic [3:0] seg_dez,
  output logic [3:0] min_uni,
  output logic [3:0] min_dez,
  output logic       running,
  output logic       lap_hold,
  output logic       overflow
);

  localparam logic [3:0] MAX_MU = 4'((WRAP_MIN - 1) % 10);
  localparam logic [3:0] MAX_MD = 4'((WRAP_MIN - 1) / 10);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_e;

  state_e     state_q, state_d;
  logic [3:0] su_q, sd_q, mu_q, md_q;
  logic [3:0] su_d, sd_d, mu_d, md_d;
  logic [3:0] dsu_q, dsd_q, dmu_q, dmd_q;
  logic       running_q, lap_hold_q, overflow_q;
  logic       wrap_d;

  always_comb begin
    su_d   = su_q;
    sd_d   = sd_q;
    mu_d   = mu_q;
    md_d   = md_q;
    wrap_d = 1'b0;
    // Ripple the BCD carry only on a tick seen while already running.
    if (tick && state_q == RUN) begin
      if (su_q != 4'd9) begin
        su_d = su_q + 4'd1;
      end else begin
        su_d = 4'd0;
        if (sd_q != 4'd5) begin
          sd_d = sd_q + 4'd1;
        end else begin
          sd_d = 4'd0;
          if (md_q == MAX_MD && mu_q == MAX_MU) begin
            mu_d   = 4'd0;
            md_d   = 4'd0;
            wrap_d = 1'b1;
          end else if (mu_q != 4'd9) begin
            mu_d = mu_q + 4'd1;
          end else begin
            mu_d = 4'd0;
            md_d = md_q + 4'd1;
          end
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (start_stop) begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      running_q  <= 1'b0;
      lap_hold_q <= 1'b0;
      overflow_q <= 1'b0;
      {su_q, sd_q, mu_q, md_q}     <= '0;
      {dsu_q, dsd_q, dmu_q, dmd_q} <= '0;
    end else if (clear) begin
      state_q    <= IDLE;
      running_q  <= 1'b0;
      lap_hold_q <= 1'b0;
      overflow_q <= 1'b0;
      {su_q, sd_q, mu_q, md_q}     <= '0;
      {dsu_q, dsd_q, dmu_q, dmd_q} <= '0;
    end else begin
      state_q    <= state_d;
      running_q  <= (state_d == RUN);
      lap_hold_q <= lap_hold_q ^ lap;
      if (wrap_d) overflow_q <= 1'b1;
      {su_q, sd_q, mu_q, md_q} <= {su_d, sd_d, mu_d, md_d};
      // Any lap edge (capture or release) and every unfrozen cycle load live time.
      if (lap || !lap_hold_q) begin
        {dsu_q, dsd_q, dmu_q, dmd_q} <= {su_d, sd_d, mu_d, md_d};
      end
    end
  end

  assign seg_uni  = dsu_q;
  assign seg_dez  = dsd_q;
  assign min_uni  = dmu_q;
  assign min_dez  = dmd_q;
  assign running  = running_q;
  assign lap_hold = lap_hold_q;
  assign overflow = overflow_q;

endmodule

// File: doc/cronometro_bcd.md
Name: cronometro_bcd

Overview:
- Downstream consumer of the mod-2 prescaler's carry pulse.
- Counts carry pulses as seconds and accumulates an MM:SS stopwatch in BCD.
- A run/pause control FSM gates counting; a lap-hold register freezes the displayed time while counting continues.
- Outputs feed the 7-segment decoder stage directly.

Parameters:
- WRAP_MIN, 60, minute modulus (legal 1..100); minutes count 0..WRAP_MIN-1 in BCD.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (asserted at 0), releases synchronously to clk
- tick  in  1  one-cycle pulse from the upstream prescaler carry; one pulse = one second
- start_stop  in  1  one-cycle pulse; toggles RUN/PAUSE
- clear  in  1  one-cycle pulse; zeroes time, returns to IDLE
- lap  in  1  one-cycle pulse; toggles display freeze
- seg_uni  out  4  displayed seconds units, BCD 0..9
- seg_dez  out  4  displayed seconds tens, BCD 0..5
- min_uni  out  4  displayed minutes units, BCD 0..9
- min_dez  out  4  displayed minutes tens, BCD 0..9
- running  out  1  1 while FSM is in RUN
- lap_hold  out  1  1 while display is frozen
- overflow  out  1  sticky; set on wrap from max time to 00:00

Behaviour:
- Reset (reset=0, asynchronous):
  - all internal counters and display registers go to 0.
  - FSM goes to IDLE; running=0, lap_hold=0, overflow=0.
- FSM states and transitions:
  - IDLE: start_stop -> RUN.
  - RUN: start_stop -> PAUSE.
  - PAUSE: start_stop -> RUN.
  - clear from any state -> IDLE.
  - running=1 only in RUN (registered, same edge as the state change).
- Counting:
  - A tick is counted only when the state before the edge is RUN.
  - The count appears on the outputs the cycle after the tick (1-cycle latency), unless lap_hold=1.
- Increment chain on each counted tick:
  - seg_uni 9->0 carries into seg_dez.
  - seg_dez 5->0 (at 59 s) carries into minutes.
  - Minutes increment in BCD (units 9->0 carries to tens).
  - At minute value WRAP_MIN-1 with 59 s, the next tick gives 00:00 and sets overflow=1.
- Digit rules:
  - No digit ever holds a non-BCD value.
  - min_dez never exceeds floor((WRAP_MIN-1)/10).
- Lap:
  - lap pulse with lap_hold=0: captures the current time into the display registers and sets lap_hold=1.
  - While lap_hold=1, internal counting continues and outputs stay frozen.
  - lap pulse with lap_hold=1: clears lap_hold; outputs track live time from the next cycle.
  - lap is honoured in any state.
- clear:
  - Zeroes internal time and display, clears lap_hold and overflow, FSM to IDLE.
  - Highest priority: overrides tick, start_stop and lap in the same cycle.
- Simultaneous events:
  - tick+start_stop in RUN: tick is counted, state goes to PAUSE.
  - tick+start_stop in PAUSE/IDLE: tick is ignored, state goes to RUN.
  - tick+lap (lap_hold=0): the capture includes the incremented value.
- tick is not required to be sparse; back-to-back ticks in consecutive cycles each count.
- overflow remains set through further wraps until clear or reset.
- Reset mid-operation (any state, any digit values): immediate return to reset values with no clk edge needed; the first tick after release is ignored because the FSM is in IDLE.

Test Plan:
- Reset then 5 ticks in IDLE -> all digits 0, running=0; start_stop, then 12 ticks -> seg_dez=1, seg_uni=2, running=1.
- RUN from 00:59, one tick -> min_uni=1, seg_dez=0, seg_uni=0 one cycle later; from 09:59 a tick -> min_dez=1, min_uni=0.
- WRAP_MIN=60 at 59:59 in RUN, tick -> 00:00, overflow=1; another 3 ticks -> 00:03, overflow still 1; clear -> overflow=0, IDLE.
- RUN at 00:10, lap, then 7 ticks -> outputs hold 00:10, lap_hold=1; lap -> outputs 00:17 next cycle.
- Same-cycle clear+tick+start_stop in RUN at 01:23 -> 00:00, IDLE, running=0; tick+start_stop in RUN at 00:04 -> 00:05, PAUSE.
- Drive reset=0 asynchronously mid-cycle at 03:41 in RUN with lap_hold=1 -> all outputs 0 before the next clk edge; after release, state IDLE.
